// File: rtl/i2s_output_stage.sv
// i2s_output_stage: rounds/saturates the reverberator output to DAC width and
// serialises it as stereo I2S (mono sample duplicated in both slots).
// Generates bclk/lrclk from clk and a frame_start strobe used upstream as the sample tick.
// Optional feature macro: SAT_STATUS_EN (adds clip_cnt, a saturating count of clamped captures).
// FIXED_POINT supplies the default number of fractional input bits.

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module i2s_output_stage #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned FP        = `FIXED_POINT,
  parameter int unsigned DAC_BITS  = 24,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned BCLK_DIV  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH+FP-1:0]   in,
  input  logic                  in_valid,
  output logic                  frame_start,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  overrun,
  output logic [15:0]           underrun_cnt
`ifdef SAT_STATUS_EN
  ,
  output logic [15:0]           clip_cnt
`endif
);

  localparam int unsigned IW         = WIDTH + FP;
  localparam int unsigned SW         = IW + 1;
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned BC_W       = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam logic [SW-1:0]        RND     = SW'(1) << (FP - 1);
  localparam logic signed [SW-1:0] DAC_MAX = {{(SW-DAC_BITS+1){1'b0}}, {(DAC_BITS-1){1'b1}}};
  localparam logic signed [SW-1:0] DAC_MIN = ~DAC_MAX;

  logic [DIV_W-1:0]    div_q;
  logic [BC_W-1:0]     bit_q;
  logic [DAC_BITS-1:0] holding_q;
  logic [DAC_BITS-1:0] frame_q;
  logic                fresh_q;

  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] shr_c;
  logic [DAC_BITS-1:0]  conv_c;
  logic                 clip_c;
  logic                 wrap_c;
  logic                 fall_c;
  logic                 load_c;
  logic [BC_W-1:0]      bit_nxt_c;
  logic [BC_W-1:0]      j_c;
  logic                 sdata_nxt_c;

  // Round half up, arithmetic shift, then clamp to the signed DAC range
  always_comb begin
    sum_c  = $signed({in[IW-1], in}) + $signed(RND);
    shr_c  = sum_c >>> FP;
    conv_c = shr_c[DAC_BITS-1:0];
    clip_c = 1'b0;
    if (shr_c > DAC_MAX) begin
      conv_c = DAC_MAX[DAC_BITS-1:0];
      clip_c = 1'b1;
    end else if (shr_c < DAC_MIN) begin
      conv_c = DAC_MIN[DAC_BITS-1:0];
      clip_c = 1'b1;
    end
  end

  // Bit clock timing: fall event, next bit position and the serial bit it carries
  always_comb begin
    wrap_c      = (div_q == DIV_W'(BCLK_DIV - 1));
    fall_c      = wrap_c && bclk;
    bit_nxt_c   = (bit_q == BC_W'(FRAME_BITS - 1)) ? '0 : bit_q + BC_W'(1);
    load_c      = fall_c && (bit_nxt_c == '0);
    j_c         = (bit_nxt_c >= BC_W'(SLOT_BITS)) ? bit_nxt_c - BC_W'(SLOT_BITS) : bit_nxt_c;
    sdata_nxt_c = 1'b0;
    for (int b = 0; b < int'(DAC_BITS); b++) begin
      if (j_c == BC_W'(int'(DAC_BITS) - b)) sdata_nxt_c = frame_q[b];
    end
  end

  // Clock divider and I2S serial outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      bit_q       <= BC_W'(FRAME_BITS - 1);
    end else begin
      div_q       <= wrap_c ? '0 : div_q + DIV_W'(1);
      frame_start <= load_c;
      if (wrap_c) bclk <= ~bclk;
      if (fall_c) begin
        bit_q <= bit_nxt_c;
        lrclk <= (bit_nxt_c >= BC_W'(SLOT_BITS));
        sdata <= sdata_nxt_c;
      end
    end
  end

  // Sample capture, frame load and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding_q    <= '0;
      frame_q      <= '0;
      fresh_q      <= 1'b0;
      overrun      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (load_c) begin
        if (fresh_q) frame_q <= holding_q;
        else if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (in_valid) holding_q <= conv_c;
      if (in_valid && fresh_q && !load_c) overrun <= 1'b1;
      if (in_valid) fresh_q <= 1'b1;
      else if (load_c) fresh_q <= 1'b0;
    end
  end

`ifdef SAT_STATUS_EN
  // Saturating count of captures that were clamped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if (in_valid && clip_c && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_output_stage.sv
// Testbench for i2s_output_stage: behavioural frame/bit-position model plus
// literal checks of the serial words seen on sdata.

module tb_i2s_output_stage;

  localparam int FP   = 8;
  localparam int DAC  = 24;
  localparam int SLOT = 32;
  localparam int D    = 2;
  localparam int FRM  = 2 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in = '0;
  logic        in_valid = 1'b0;
  logic        frame_start, bclk, lrclk, sdata, overrun;
  logic [15:0] underrun_cnt;
`ifdef SAT_STATUS_EN
  logic [15:0] clip_cnt;
`endif

  always #5 clk = ~clk;

  i2s_output_stage #(
    .WIDTH(24), .FP(FP), .DAC_BITS(DAC), .SLOT_BITS(SLOT), .BCLK_DIV(D)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
    .frame_start(frame_start), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .overrun(overrun), .underrun_cnt(underrun_cnt)
`ifdef SAT_STATUS_EN
    , .clip_cnt(clip_cnt)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  // Model state: k = clk edges since reset release
  int          k;
  int          m_bit;
  logic [23:0] m_hold, m_frame;
  bit          m_fresh, m_over, m_fs, m_fall;
  int          m_under, m_clip;
  logic [23:0] cap_l, cap_r, last_l, last_r;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] conv(input logic [31:0] d, output bit clipped);
    longint v, r;
    v = $signed(d);
    r = (v + (longint'(1) << (FP - 1))) >>> FP;
    clipped = 1'b0;
    if (r > 64'sd8388607) begin r = 64'sd8388607; clipped = 1'b1; end
    if (r < -64'sd8388608) begin r = -64'sd8388608; clipped = 1'b1; end
    return 24'(r);
  endfunction

  task automatic model_reset();
    k = 0; m_bit = 63; m_hold = '0; m_frame = '0; m_fresh = 0; m_over = 0;
    m_fs = 0; m_fall = 0; m_under = 0; m_clip = 0;
    cap_l = '0; cap_r = '0; last_l = '0; last_r = '0;
  endtask

  function automatic bit next_is_load();
    int kn;
    kn = k + 1;
    return (kn % (2 * D) == 0) && (((63 + kn / (2 * D)) % FRM) == 0);
  endfunction

  // One clk cycle: apply inputs, advance model across the posedge, compare at negedge
  task automatic cycle(input bit v, input logic [31:0] d);
    bit load, clipped;
    int j;
    logic [23:0] cv;
    logic e_bclk, e_lr, e_sd;
    in_valid = v;
    in = d;
    @(negedge clk);
    k++;
    m_fall = (k % (2 * D) == 0);
    m_bit  = (63 + k / (2 * D)) % FRM;
    load   = m_fall && (m_bit == 0);
    m_fs   = load;
    if (load) begin
      if (m_fresh) m_frame = m_hold;
      else if (m_under < 65535) m_under++;
    end
    if (v && m_fresh && !load) m_over = 1'b1;
    if (v) begin
      cv = conv(d, clipped);
      m_hold = cv;
      m_fresh = 1'b1;
      if (clipped && m_clip < 65535) m_clip++;
    end else if (load) begin
      m_fresh = 1'b0;
    end
    j      = m_bit % SLOT;
    e_bclk = ((k / D) % 2) == 1;
    e_lr   = (k >= 2 * D) && (m_bit >= SLOT);
    e_sd   = 1'b0;
    if (k >= 2 * D && j >= 1 && j <= DAC) e_sd = m_frame[DAC - j];
    check("bclk", bclk, e_bclk);
    check("lrclk", lrclk, e_lr);
    check("sdata", sdata, e_sd);
    check("frame_start", frame_start, m_fs);
    check("overrun", overrun, m_over);
    check("underrun_cnt", underrun_cnt, m_under);
`ifdef SAT_STATUS_EN
    check("clip_cnt", clip_cnt, m_clip);
`endif
    if (load) begin
      last_l = cap_l; last_r = cap_r; cap_l = '0; cap_r = '0;
    end
    if (m_fall && j >= 1 && j <= DAC) begin
      if (m_bit < SLOT) cap_l = {cap_l[22:0], sdata};
      else              cap_r = {cap_r[22:0], sdata};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  task automatic run_until_before_load();
    int n;
    n = 0;
    while (!next_is_load() && n < 400) begin
      cycle(1'b0, '0);
      n++;
    end
    if (n >= 400) begin
      mismatched++;
      $display("FAIL load_timeout: no frame boundary within %0d cycles", n);
    end
  endtask

  task automatic run_to_load();
    run_until_before_load();
    cycle(1'b0, '0);
  endtask

  task automatic pin_word(input string name, input logic [23:0] exp);
    check({name, "_left"}, last_l, exp);
    check({name, "_right"}, last_r, exp);
  endtask

  initial begin
    int u0, n;
    model_reset();
    #1;
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_underrun", underrun_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First frame after reset is an underrun
    run_to_load();
    check("first_fs", frame_start, 1);
    check("first_underrun", underrun_cnt, 1);

    // Basic rounding: 0x00123480 -> 0x001235
    idle(10);
    cycle(1'b1, 32'h0012_3480);
    run_to_load();
    check("fresh_load_underrun", underrun_cnt, 1);
    run_to_load();
    pin_word("word_001235", 24'h001235);

    // Saturation at both ends
    cycle(1'b1, 32'h7FFF_FFFF);
    run_to_load();
    run_to_load();
    pin_word("word_pos_sat", 24'h7FFFFF);
    cycle(1'b1, 32'h8000_0000);
    run_to_load();
    run_to_load();
    pin_word("word_neg_full", 24'h800000);

    // in_valid on the exact load cycle: no overrun, both samples delivered
    cycle(1'b1, 32'h0000_0100);
    run_until_before_load();
    cycle(1'b1, 32'h0000_0300);
    check("sim_fs", frame_start, 1);
    run_to_load();
    pin_word("word_sim_first", 24'h000001);
    run_to_load();
    pin_word("word_sim_second", 24'h000003);
    check("sim_no_overrun", overrun, 0);

    // Repeat last sample through three empty frames
    cycle(1'b1, 32'h0000_0500);
    run_to_load();
    u0 = m_under;
    for (int f = 0; f < 3; f++) begin
      run_to_load();
      pin_word("word_repeat", 24'h000005);
    end
    check("repeat_underrun", underrun_cnt, u0 + 3);

    // Two samples in one frame: second wins, overrun sticks
    cycle(1'b1, 32'h0000_0100);
    idle(5);
    cycle(1'b1, 32'h0000_0200);
    run_to_load();
    run_to_load();
    pin_word("word_overrun", 24'h000002);
    check("overrun_set", overrun, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 20 * 2 * D * FRM; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h00FF_FFFF);
      cycle($urandom_range(0, 149) == 0, d);
    end

    // Asynchronous reset mid-frame at bit 40 while bclk is high
    n = 0;
    while (!(m_bit == 40 && ((k / D) % 2) == 1) && n < 600) begin
      cycle(1'b0, '0);
      n++;
    end
    if (n >= 600) begin
      mismatched++;
      $display("FAIL bit40_timeout: bit 40 not reached");
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_bclk", bclk, 0);
    check("mid_rst_lrclk", lrclk, 0);
    check("mid_rst_sdata", sdata, 0);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_underrun", underrun_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("post_rst_fs", frame_start, 1);
    check("post_rst_underrun", underrun_cnt, 1);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
